// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants for the ALU command sequencer: FSM state codes, command kinds,
// write-back mux selects and the ALU no-op opcode.
package alu_seq_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_WB    = 3'd4;
    localparam state_t ST_RESP  = 3'd5;

    localparam logic [1:0] KIND_NOP  = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_ALU  = 2'b10;
    localparam logic [1:0] KIND_ILL  = 2'b11;

    localparam logic [1:0] MUX_IR  = 2'b00;
    localparam logic [1:0] MUX_ALU = 2'b01;
    localparam logic [1:0] MUX_DIN = 2'b10;

    localparam int unsigned OP_NOP = 32'd0;

endpackage

// File: rtl/seq_timeout_cnt.sv
// WAIT-state cycle counter: cleared outside WAIT, counts while enabled and
// flags the last permitted WAIT cycle.
module seq_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_r;

    assign expired = (cnt_r == 8'(TIMEOUT - 1));

    // Cycle counter, saturating at the expiry value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (clear) begin
            cnt_r <= 8'd0;
        end else if (enable && !expired) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving a register file / ALU datapath: LOAD immediates,
// issue ALU ops, wait for results with timeout, write back and respond.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int SEG_WL  = 4,
    parameter int ADR_WL  = 4,
    parameter int OP_WL   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              a_reset_h,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [OP_WL-1:0]  cmd_op,
    input  logic [SEG_WL-1:0] cmd_seg,
    input  logic [ADR_WL-1:0] cmd_dst,
    input  logic [ADR_WL-1:0] cmd_src_a,
    input  logic [ADR_WL-1:0] cmd_src_b,
    input  logic [15:0]       cmd_imm,
    input  logic              alu_valid,
    input  logic [15:0]       alu_data,
    output logic [SEG_WL-1:0] seg_reg,
    output logic [ADR_WL-1:0] adr_reg_a,
    output logic [ADR_WL-1:0] adr_reg_b,
    output logic [OP_WL-1:0]  op_in,
    output logic [1:0]        mux_sel,
    output logic              we,
    output logic [15:0]       data_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic              rsp_err
);

    localparam logic [OP_WL-1:0]  OP_NOP_W = OP_WL'(OP_NOP);
    localparam logic [SEG_WL-1:0] SEG_ZERO = {SEG_WL{1'b0}};
    localparam logic [ADR_WL-1:0] ADR_ZERO = {ADR_WL{1'b0}};

    state_t             state_r, state_nxt_s;
    logic [SEG_WL-1:0]  seg_r, seg_n_s;
    logic [ADR_WL-1:0]  dst_r, dst_n_s, src_a_r, src_a_n_s, src_b_r, src_b_n_s;
    logic [OP_WL-1:0]   op_r, op_n_s;
    logic [15:0]        imm_r, imm_n_s, alu_cap_r, alu_cap_nxt_s;
    logic               handshake_s, expired_s;

    logic               cmd_ready_r, cmd_ready_nxt_s;
    logic [SEG_WL-1:0]  seg_reg_r, seg_reg_nxt_s;
    logic [ADR_WL-1:0]  adr_a_r, adr_a_nxt_s, adr_b_r, adr_b_nxt_s;
    logic [OP_WL-1:0]   op_in_r, op_in_nxt_s;
    logic [1:0]         mux_sel_r, mux_sel_nxt_s;
    logic               we_r, we_nxt_s, rsp_valid_r, rsp_valid_nxt_s, rsp_err_r, rsp_err_nxt_s;
    logic [15:0]        data_out_r, data_out_nxt_s, rsp_data_r, rsp_data_nxt_s;

    seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (a_reset_h),
        .clear   (state_r != ST_WAIT),
        .enable  (state_r == ST_WAIT),
        .expired (expired_s)
    );

    // Next state, response values, and outputs decoded from the next state so they leave a flop
    always_comb begin
        handshake_s     = (state_r == ST_IDLE) && cmd_valid;
        seg_n_s         = handshake_s ? cmd_seg   : seg_r;
        dst_n_s         = handshake_s ? cmd_dst   : dst_r;
        src_a_n_s       = handshake_s ? cmd_src_a : src_a_r;
        src_b_n_s       = handshake_s ? cmd_src_b : src_b_r;
        op_n_s          = handshake_s ? cmd_op    : op_r;
        imm_n_s         = handshake_s ? cmd_imm   : imm_r;
        state_nxt_s     = state_r;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        alu_cap_nxt_s   = alu_cap_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_kind)
                        KIND_LOAD: state_nxt_s = ST_LOAD;
                        KIND_ALU:  state_nxt_s = ST_ISSUE;
                        KIND_NOP: begin
                            state_nxt_s    = ST_RESP;
                            rsp_data_nxt_s = 16'h0000;
                            rsp_err_nxt_s  = 1'b0;
                        end
                        KIND_ILL: begin
                            state_nxt_s    = ST_RESP;
                            rsp_data_nxt_s = 16'h0000;
                            rsp_err_nxt_s  = 1'b1;
                        end
                        default: begin
                            state_nxt_s    = ST_RESP;
                            rsp_data_nxt_s = 16'h0000;
                            rsp_err_nxt_s  = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s    = ST_RESP;
                rsp_data_nxt_s = imm_r;
                rsp_err_nxt_s  = 1'b0;
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                // A result arriving in the expiry cycle still counts as success
                if (alu_valid) begin
                    state_nxt_s   = ST_WB;
                    alu_cap_nxt_s = alu_data;
                end else if (expired_s) begin
                    state_nxt_s    = ST_RESP;
                    rsp_data_nxt_s = 16'h0000;
                    rsp_err_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WB: begin
                state_nxt_s    = ST_RESP;
                rsp_data_nxt_s = alu_cap_r;
                rsp_err_nxt_s  = 1'b0;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s    = ST_IDLE;
                    rsp_data_nxt_s = 16'h0000;
                    rsp_err_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                rsp_data_nxt_s = 16'h0000;
                rsp_err_nxt_s  = 1'b0;
            end
        endcase

        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
        seg_reg_nxt_s   = SEG_ZERO;
        adr_a_nxt_s     = ADR_ZERO;
        adr_b_nxt_s     = ADR_ZERO;
        op_in_nxt_s     = OP_NOP_W;
        mux_sel_nxt_s   = MUX_IR;
        we_nxt_s        = 1'b0;
        data_out_nxt_s  = 16'h0000;

        case (state_nxt_s)
            ST_LOAD: begin
                we_nxt_s       = 1'b1;
                mux_sel_nxt_s  = MUX_DIN;
                data_out_nxt_s = imm_n_s;
                adr_a_nxt_s    = dst_n_s;
                seg_reg_nxt_s  = seg_n_s;
            end
            ST_ISSUE, ST_WAIT: begin
                op_in_nxt_s   = op_n_s;
                adr_a_nxt_s   = src_a_n_s;
                adr_b_nxt_s   = src_b_n_s;
                seg_reg_nxt_s = seg_n_s;
            end
            ST_WB: begin
                we_nxt_s      = 1'b1;
                mux_sel_nxt_s = MUX_ALU;
                adr_a_nxt_s   = dst_n_s;
                seg_reg_nxt_s = seg_n_s;
            end
            default: begin
                we_nxt_s = 1'b0;
            end
        endcase
    end

    // State, command capture and registered outputs
    always_ff @(posedge clk or posedge a_reset_h) begin
        if (a_reset_h) begin
            state_r     <= ST_IDLE;
            seg_r       <= SEG_ZERO;
            dst_r       <= ADR_ZERO;
            src_a_r     <= ADR_ZERO;
            src_b_r     <= ADR_ZERO;
            op_r        <= OP_NOP_W;
            imm_r       <= 16'h0000;
            alu_cap_r   <= 16'h0000;
            cmd_ready_r <= 1'b1;
            seg_reg_r   <= SEG_ZERO;
            adr_a_r     <= ADR_ZERO;
            adr_b_r     <= ADR_ZERO;
            op_in_r     <= OP_NOP_W;
            mux_sel_r   <= MUX_IR;
            we_r        <= 1'b0;
            data_out_r  <= 16'h0000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            seg_r       <= seg_n_s;
            dst_r       <= dst_n_s;
            src_a_r     <= src_a_n_s;
            src_b_r     <= src_b_n_s;
            op_r        <= op_n_s;
            imm_r       <= imm_n_s;
            alu_cap_r   <= alu_cap_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
            seg_reg_r   <= seg_reg_nxt_s;
            adr_a_r     <= adr_a_nxt_s;
            adr_b_r     <= adr_b_nxt_s;
            op_in_r     <= op_in_nxt_s;
            mux_sel_r   <= mux_sel_nxt_s;
            we_r        <= we_nxt_s;
            data_out_r  <= data_out_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign seg_reg   = seg_reg_r;
    assign adr_reg_a = adr_a_r;
    assign adr_reg_b = adr_b_r;
    assign op_in     = op_in_r;
    assign mux_sel   = mux_sel_r;
    assign we        = we_r;
    assign data_out  = data_out_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl: LOAD, ALU, timeout, illegal,
// NOP, mid-command reset and back-to-back traffic.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        a_reset_h;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_kind;
    logic [7:0]  cmd_op;
    logic [3:0]  cmd_seg, cmd_dst, cmd_src_a, cmd_src_b;
    logic [15:0] cmd_imm;
    logic        alu_valid;
    logic [15:0] alu_data;
    logic [3:0]  seg_reg, adr_reg_a, adr_reg_b;
    logic [7:0]  op_in;
    logic [1:0]  mux_sel;
    logic        we;
    logic [15:0] data_out;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int we_cnt = 0;
    int hs_cnt = 0;
    int t0 = 0;

    alu_seq_ctrl #(.SEG_WL(4), .ADR_WL(4), .OP_WL(8), .TIMEOUT(16)) dut (
        .clk(clk), .a_reset_h(a_reset_h),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_seg(cmd_seg), .cmd_dst(cmd_dst),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
        .alu_valid(alu_valid), .alu_data(alu_data),
        .seg_reg(seg_reg), .adr_reg_a(adr_reg_a), .adr_reg_b(adr_reg_b),
        .op_in(op_in), .mux_sel(mux_sel), .we(we), .data_out(data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Edge-sampled monitor: cycle count, write pulses, accepted commands
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (we) we_cnt = we_cnt + 1;
        if (cmd_valid && cmd_ready) hs_cnt = hs_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] kind, input logic [7:0] op, input logic [3:0] seg,
                        input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [15:0] imm);
        check_eq("ready_before_cmd", cmd_ready, 1);
        cmd_kind = kind; cmd_op = op; cmd_seg = seg; cmd_dst = dst;
        cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_arrives", rsp_valid, 1);
        lat = cyc - t0 + 1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("idle_ready_after_rsp", cmd_ready, 1);
        check_eq("rsp_valid_dropped", rsp_valid, 0);
    endtask

    initial begin
        int lat, w0, h0, prev;
        a_reset_h = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_op = 8'h00;
        cmd_seg = 4'd0; cmd_dst = 4'd0; cmd_src_a = 4'd0; cmd_src_b = 4'd0;
        cmd_imm = 16'h0000; alu_valid = 1'b0; alu_data = 16'h0000; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_we", we, 0);
        check_eq("rst_op_in", op_in, 0);
        check_eq("rst_mux", mux_sel, 0);
        check_eq("rst_addr_seg_data", {adr_reg_a, adr_reg_b, seg_reg, data_out}, 0);
        a_reset_h = 1'b0;
        @(negedge clk);

        // LOAD, with stray alu_valid that must be ignored
        w0 = we_cnt;
        alu_valid = 1'b1; alu_data = 16'hDEAD;
        send(2'b01, 8'h00, 4'd5, 4'd3, 4'd0, 4'd0, 16'hBEEF);
        check_eq("load_we", we, 1);
        check_eq("load_mux", mux_sel, 2'b10);
        check_eq("load_adr_a", adr_reg_a, 3);
        check_eq("load_data_out", data_out, 16'hBEEF);
        check_eq("load_seg", seg_reg, 5);
        check_eq("load_cmd_ready", cmd_ready, 0);
        alu_valid = 1'b0;
        wait_rsp(lat);
        check_eq("load_latency", lat, 2);
        check_eq("load_rsp_data", rsp_data, 16'hBEEF);
        check_eq("load_rsp_err", rsp_err, 0);
        check_eq("load_resp_we", we, 0);
        check_eq("load_resp_mux", mux_sel, 2'b00);
        consume();
        check_eq("load_we_count", we_cnt - w0, 1);

        // ALU with result in the third WAIT cycle
        w0 = we_cnt;
        send(2'b10, 8'h05, 4'd6, 4'd4, 4'd1, 4'd2, 16'h0000);
        check_eq("issue_op", op_in, 8'h05);
        check_eq("issue_adr_a", adr_reg_a, 1);
        check_eq("issue_adr_b", adr_reg_b, 2);
        check_eq("issue_seg", seg_reg, 6);
        check_eq("issue_we", we, 0);
        @(negedge clk);
        check_eq("wait_op_hold", op_in, 8'h05);
        check_eq("wait_adr_b_hold", adr_reg_b, 2);
        @(negedge clk);
        @(negedge clk);
        alu_valid = 1'b1; alu_data = 16'h1234;
        @(negedge clk);
        alu_valid = 1'b0; alu_data = 16'h0000;
        check_eq("wb_we", we, 1);
        check_eq("wb_mux", mux_sel, 2'b01);
        check_eq("wb_adr_a", adr_reg_a, 4);
        check_eq("wb_op_nop", op_in, 0);
        wait_rsp(lat);
        check_eq("alu_latency", lat, 6);
        check_eq("alu_rsp_data", rsp_data, 16'h1234);
        check_eq("alu_rsp_err", rsp_err, 0);
        consume();
        check_eq("alu_we_count", we_cnt - w0, 1);

        // ALU timeout: no alu_valid at all
        w0 = we_cnt;
        send(2'b10, 8'h22, 4'd0, 4'd9, 4'd3, 4'd4, 16'h0000);
        wait_rsp(lat);
        check_eq("tmo_latency", lat, 18);
        check_eq("tmo_rsp_err", rsp_err, 1);
        check_eq("tmo_rsp_data", rsp_data, 0);
        consume();
        check_eq("tmo_no_write", we_cnt - w0, 0);

        // alu_valid in the last WAIT cycle wins over timeout
        w0 = we_cnt;
        send(2'b10, 8'h33, 4'd1, 4'd8, 4'd5, 4'd6, 16'h0000);
        repeat (16) @(negedge clk);
        alu_valid = 1'b1; alu_data = 16'hA5A5;
        @(negedge clk);
        alu_valid = 1'b0; alu_data = 16'h0000;
        check_eq("edge_wb_we", we, 1);
        check_eq("edge_wb_adr_a", adr_reg_a, 8);
        wait_rsp(lat);
        check_eq("edge_latency", lat, 19);
        check_eq("edge_rsp_data", rsp_data, 16'hA5A5);
        check_eq("edge_rsp_err", rsp_err, 0);
        consume();
        check_eq("edge_we_count", we_cnt - w0, 1);

        // Illegal kind, response held while rsp_ready stays low
        w0 = we_cnt;
        send(2'b11, 8'h00, 4'd0, 4'd2, 4'd0, 4'd0, 16'h7777);
        wait_rsp(lat);
        check_eq("ill_latency", lat, 1);
        h0 = hs_cnt;
        cmd_kind = 2'b01; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("ill_hold_valid", rsp_valid, 1);
            check_eq("ill_hold_err", rsp_err, 1);
            check_eq("ill_hold_data", rsp_data, 0);
            check_eq("ill_hold_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        check_eq("ill_no_accept", hs_cnt - h0, 0);
        consume();

        // NOP
        send(2'b00, 8'h00, 4'd0, 4'd2, 4'd0, 4'd0, 16'h5555);
        wait_rsp(lat);
        check_eq("nop_latency", lat, 1);
        check_eq("nop_rsp_err", rsp_err, 0);
        check_eq("nop_rsp_data", rsp_data, 0);
        consume();
        check_eq("ill_nop_no_write", we_cnt - w0, 0);

        // Reset during WAIT aborts the command
        w0 = we_cnt;
        send(2'b10, 8'h44, 4'd2, 4'd5, 4'd6, 4'd7, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        a_reset_h = 1'b1;
        #1;
        check_eq("mid_rst_ready", cmd_ready, 1);
        check_eq("mid_rst_we", we, 0);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_op", op_in, 0);
        check_eq("mid_rst_adr_a", adr_reg_a, 0);
        @(negedge clk);
        a_reset_h = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("post_rst_rsp_valid", rsp_valid, 0);
        check_eq("post_rst_no_write", we_cnt - w0, 0);
        send(2'b01, 8'h00, 4'd1, 4'd7, 4'd0, 4'd0, 16'h1357);
        check_eq("post_rst_load_we", we, 1);
        check_eq("post_rst_load_adr", adr_reg_a, 7);
        wait_rsp(lat);
        check_eq("post_rst_latency", lat, 2);
        check_eq("post_rst_rsp_data", rsp_data, 16'h1357);
        consume();

        // Back-to-back LOADs with rsp_ready tied high
        rsp_ready = 1'b1;
        w0 = we_cnt; h0 = hs_cnt; prev = 0;
        cmd_kind = 2'b01; cmd_seg = 4'd3; cmd_dst = 4'd0; cmd_imm = 16'h1000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("b2b_accept_count", hs_cnt - h0, i + 1);
            check_eq("b2b_we", we, 1);
            check_eq("b2b_data_out", data_out, 16'h1000 + i);
            check_eq("b2b_adr_a", adr_reg_a, i);
            if (i > 0) check_eq("b2b_spacing", cyc - prev, 3);
            prev = cyc;
            if (i < 3) begin
                cmd_dst = 4'(i + 1); cmd_imm = 16'h1000 + 16'(i + 1);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("b2b_rsp_valid", rsp_valid, 1);
            check_eq("b2b_rsp_data", rsp_data, 16'h1000 + i);
            @(negedge clk);
            check_eq("b2b_idle_ready", cmd_ready, 1);
        end
        @(negedge clk);
        check_eq("b2b_we_total", we_cnt - w0, 4);
        check_eq("b2b_accept_total", hs_cnt - h0, 4);
        rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end

endmodule
